// File: rtl/nco_cfg_pkg.sv
// Shared types and constants for the simple_nco configuration writer.
package nco_cfg_pkg;

   typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, SETTLE, DONE} state_e;
   typedef enum logic [1:0] {OFF, SINE, SQUARE, SAW} mode_e;

   localparam int unsigned MODE_LSB = 0;
   localparam int unsigned LD_LO    = 2;
   localparam int unsigned LD_HI    = 3;

   // Must track the NCO's own FCW reset value so the shadow stays coherent.
   localparam logic [15:0] NCO_FCW_RESET = 16'h0008;

endpackage

// File: rtl/nco_cfg_writer.sv
// Sequences byte-wide FCW/mode loads into simple_nco, skipping bytes the NCO
// already holds (tracked by a shadow copy) unless a forced write is requested.
module nco_cfg_writer
   import nco_cfg_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter logic [15:0] FCW_RESET     = NCO_FCW_RESET
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic [15:0] reqFcw,
   input  logic [1:0]  reqMode,
   input  logic        reqForce,
   output logic [7:0]  ctrlOut,
   output logic [7:0]  dataOut,
   output logic        busy,
   output logic        cfgDone
);

   localparam int unsigned CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
   localparam state_e POST_WR = (SETTLE_CYCLES > 0) ? SETTLE : DONE;

   state_e        state_q, state_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [7:0]    fcw_hi_q, fcw_hi_d;
   logic          need_hi_q, need_hi_d;
   logic [3:0]    ctrl_q, ctrl_d;
   logic [7:0]    data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          need_lo, need_hi;

   assign reqReady = (state_q == IDLE) & enable;
   assign need_lo  = reqForce | (reqFcw[7:0]  != shadow_q[7:0]);
   assign need_hi  = reqForce | (reqFcw[15:8] != shadow_q[15:8]);

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      fcw_hi_d  = fcw_hi_q;
      need_hi_d = need_hi_q;
      ctrl_d    = ctrl_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (reqValid && reqReady) begin
               fcw_hi_d                 = reqFcw[15:8];
               need_hi_d                = need_hi;
               ctrl_d[MODE_LSB +: 2]    = reqMode;
               if (need_lo) begin
                  state_d          = WR_LO;
                  ctrl_d[LD_LO]    = 1'b1;
                  data_d           = reqFcw[7:0];
                  shadow_d[7:0]    = reqFcw[7:0];
               end else if (need_hi) begin
                  state_d          = WR_HI;
                  ctrl_d[LD_HI]    = 1'b1;
                  data_d           = reqFcw[15:8];
                  shadow_d[15:8]   = reqFcw[15:8];
               end else begin
                  state_d          = DONE;
               end
            end
         end
         WR_LO: begin
            ctrl_d[LD_LO] = 1'b0;
            if (need_hi_q) begin
               state_d        = WR_HI;
               ctrl_d[LD_HI]  = 1'b1;
               data_d         = fcw_hi_q;
               shadow_d[15:8] = fcw_hi_q;
            end else begin
               state_d = POST_WR;
               data_d  = '0;
               cnt_d   = CNT_INIT;
            end
         end
         WR_HI: begin
            ctrl_d[LD_HI] = 1'b0;
            data_d        = '0;
            state_d       = POST_WR;
            cnt_d         = CNT_INIT;
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Everything freezes while enable is low, matching the NCO's own gating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shadow_q  <= FCW_RESET;
         fcw_hi_q  <= '0;
         need_hi_q <= 1'b0;
         ctrl_q    <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
      end else if (enable) begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         fcw_hi_q  <= fcw_hi_d;
         need_hi_q <= need_hi_d;
         ctrl_q    <= ctrl_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ctrlOut = {4'b0000, ctrl_q};
   assign dataOut = data_q;
   assign busy    = (state_q != IDLE);
   assign cfgDone = (state_q == DONE);

endmodule

// File: tb/tb_nco_cfg_writer.sv
// Directed bench for nco_cfg_writer: hand-computed cycle-by-cycle output vectors.
module tb_nco_cfg_writer;

   logic        clk, rst_n, enable, reqValid, reqReady, reqForce, busy, cfgDone;
   logic [15:0] reqFcw;
   logic [1:0]  reqMode;
   logic [7:0]  ctrlOut, dataOut;
   int          checks = 0;
   int          errors = 0;

   nco_cfg_writer #(.SETTLE_CYCLES(3), .FCW_RESET(16'h0008)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .reqValid(reqValid), .reqReady(reqReady), .reqFcw(reqFcw),
      .reqMode(reqMode), .reqForce(reqForce),
      .ctrlOut(ctrlOut), .dataOut(dataOut), .busy(busy), .cfgDone(cfgDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // exp layout: ctrl, data, busy, cfgDone, reqReady
   task automatic chk(input string tag, input logic [7:0] c, input logic [7:0] d,
                      input logic b, input logic dn, input logic r);
      logic [18:0] obs, exp;
      obs = {ctrlOut, dataOut, busy, cfgDone, reqReady};
      exp = {c, d, b, dn, r};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got ctrl=%h data=%h busy/done/rdy=%b%b%b, want ctrl=%h data=%h busy/done/rdy=%b%b%b",
                tag, ctrlOut, dataOut, busy, cfgDone, reqReady, c, d, b, dn, r);
      end
   endtask

   task automatic req(input logic [15:0] f, input logic [1:0] m, input logic frc);
      reqValid = 1'b1;
      reqFcw   = f;
      reqMode  = m;
      reqForce = frc;
      tick();
      reqValid = 1'b0;
      reqForce = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; reqValid = 1'b0;
      reqFcw = '0; reqMode = '0; reqForce = 1'b0;
      #12;
      chk("reset", 8'h00, 8'h00, 0, 0, 1);
      rst_n = 1'b1;
      tick();
      chk("idle", 8'h00, 8'h00, 0, 0, 1);

      // Full write, both bytes differ from reset shadow
      req(16'h1234, 2'd1, 1'b0);
      chk("t1_lo", 8'h05, 8'h34, 1, 0, 0);
      tick(); chk("t1_hi", 8'h09, 8'h12, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); chk("t1_settle", 8'h01, 8'h00, 1, 0, 0);
      end
      tick(); chk("t1_done", 8'h01, 8'h00, 1, 1, 0);
      tick(); chk("t1_ready", 8'h01, 8'h00, 0, 0, 1);

      // Only low byte changes
      req(16'h1299, 2'd2, 1'b0);
      chk("t2_lo", 8'h06, 8'h99, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); chk("t2_settle", 8'h02, 8'h00, 1, 0, 0);
      end
      tick(); chk("t2_done", 8'h02, 8'h00, 1, 1, 0);
      tick(); chk("t2_ready", 8'h02, 8'h00, 0, 0, 1);

      // Mode-only change: no strobe
      req(16'h1299, 2'd3, 1'b0);
      chk("t3_done", 8'h03, 8'h00, 1, 1, 0);
      tick(); chk("t3_ready", 8'h03, 8'h00, 0, 0, 1);

      // Forced rewrite of identical FCW
      req(16'h1299, 2'd3, 1'b1);
      chk("t4_lo", 8'h07, 8'h99, 1, 0, 0);
      tick(); chk("t4_hi", 8'h0B, 8'h12, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); chk("t4_settle", 8'h03, 8'h00, 1, 0, 0);
      end
      tick(); chk("t4_done", 8'h03, 8'h00, 1, 1, 0);
      tick(); chk("t4_ready", 8'h03, 8'h00, 0, 0, 1);

      // Enable stall inside WR_LO
      req(16'h5678, 2'd1, 1'b0);
      chk("t5_lo", 8'h05, 8'h78, 1, 0, 0);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); chk("t5_hold", 8'h05, 8'h78, 1, 0, 0);
      end
      enable = 1'b1;
      tick(); chk("t5_hi", 8'h09, 8'h56, 1, 0, 0);

      // Asynchronous reset during WR_HI
      rst_n = 1'b0;
      #1;
      chk("t5_rst_async", 8'h00, 8'h00, 0, 0, 1);
      tick(); chk("t5_rst_hold", 8'h00, 8'h00, 0, 0, 1);
      rst_n = 1'b1;
      tick(); chk("t5_rst_idle", 8'h00, 8'h00, 0, 0, 1);

      // Shadow is back at reset FCW: no strobes expected
      req(16'h0008, 2'd0, 1'b0);
      chk("t6_done", 8'h00, 8'h00, 1, 1, 0);
      tick(); chk("t6_ready", 8'h00, 8'h00, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
